regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A (ALU/execute) and B (memory load return).
- Tracks per-register pending writes in a scoreboard so decode can stall on read-after-write hazards.
- Sits between the execute/memory stages and the 8x16 register file.
- Drives the file's load, dest and in pins directly, all registered.

Parameters:
- NREG, 8, number of architectural registers; fixed at 8 (3-bit index).
- DW, 16, data width.
- CW, 2, scoreboard counter width per register; max outstanding writes per register = 2^CW-1 = 3.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  requester A has a write
- a_dest  in  3  A destination register
- a_data  in  16  A write data
- a_ready  out  1  A accepted this cycle (combinational)
- b_valid  in  1  requester B has a write
- b_dest  in  3  B destination register
- b_data  in  16  B write data
- b_ready  out  1  B accepted this cycle (combinational)
- issue_valid  in  1  decode reserves a future write
- issue_dest  in  3  register being reserved
- issue_ready  out  1  reservation accepted (combinational)
- src_a  in  3  decode source index A
- src_b  in  3  decode source index B
- hazard  out  1  src_a or src_b has a pending write (combinational)
- rf_load  out  1  register file load strobe (registered)
- rf_dest  out  3  register file dest (registered)
- rf_in  out  16  register file write data (registered)
- busy  out  8  busy[i] = pending count of register i is nonzero
- err_underflow  out  1  sticky: a write occurred to an unreserved register

Behaviour:
- Reset: rf_load=0, rf_dest=0, rf_in=0, all counters 0 (busy=0), err_underflow=0, last_grant=B (so A wins the first tie). Reset mid-operation discards in-flight grants and reservations.
- Arbitration, combinational within the cycle:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the one not equal to last_grant (round-robin).
  - a_ready = grant A; b_ready = grant B; never both. A request is consumed only when valid and ready are both high.
  - last_grant updates only on a cycle with a grant.
- Write latency: grant in cycle N gives rf_load=1, rf_dest/rf_in = the granted dest/data in cycle N+1. The register file captures the write on the N+1 rising edge.
  - No grant: rf_load=0; rf_dest/rf_in hold their previous values.
  - Back-to-back grants give one write per cycle, 100% port utilisation.
- Scoreboard, per register i, counter cnt[i] (0..3):
  - inc = issue_valid & issue_ready & issue_dest==i.
  - dec = rf_load & rf_dest==i. Decrement happens at the same edge the file writes.
  - inc and dec together: cnt unchanged.
  - inc only: cnt+1.
  - dec only: if cnt>0 then cnt-1; else cnt stays 0 and err_underflow is set (sticky until reset).
- issue_ready = (cnt[issue_dest] != 3) OR a dec to the same register occurs this cycle.
- hazard = busy[src_a] | busy[src_b], evaluated on current counters. No bypass: a register being written this cycle still reads as busy until the next cycle.
- Inputs are sampled without validation; X on valid signals is a bench error.

Test Plan:
- Reset, then a_valid=1, a_dest=3, a_data=16'h1234 for one cycle -> a_ready=1 that cycle; next cycle rf_load=1, rf_dest=3, rf_in=16'h1234; the cycle after, rf_load=0.
- a_valid and b_valid held high for 4 cycles (A dest 1, data 16'hAAAA; B dest 2, data 16'hBBBB) -> grants alternate A,B,A,B; rf_dest sequence 1,2,1,2 one cycle later.
- Issue dest 5 three times -> cnt[5]=3, busy[5]=1; fourth issue to 5 -> issue_ready=0; src_a=5 -> hazard=1.
- Three writebacks to reg 5 -> busy[5] clears the cycle after the third rf_load; hazard=0.
- With cnt[5]=3, issue dest 5 in the same cycle rf_load writes reg 5 -> issue_ready=1, cnt stays 3.
- Write to reg 7 with cnt[7]=0 -> err_underflow=1 and stays 1; cnt[7]=0; after reset, err_underflow=0.
- Assert reset in the cycle after a grant -> rf_load=0 next cycle, busy=8'h00, last_grant=B; a subsequent tie is granted to A.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requests, reservations, decode sources and register-file write port.
interface regfile_wb_arbiter_if #(parameter int DW = 16);
  logic a_valid, a_ready, b_valid, b_ready, issue_valid, issue_ready, hazard, rf_load, err_underflow;
  logic [2:0] a_dest, b_dest, issue_dest, src_a, src_b, rf_dest;
  logic [DW-1:0] a_data, b_data, rf_in;
  logic [7:0] busy;
  modport slave (
    input a_valid, a_dest, a_data, b_valid, b_dest, b_data, issue_valid, issue_dest, src_a, src_b,
    output a_ready, b_ready, issue_ready, hazard, rf_load, rf_dest, rf_in, busy, err_underflow
  );
  modport master (
    output a_valid, a_dest, a_data, b_valid, b_dest, b_data, issue_valid, issue_dest, src_a, src_b,
    input a_ready, b_ready, issue_ready, hazard, rf_load, rf_dest, rf_in, busy, err_underflow
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port plus per-register pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int NREG = 8,
  parameter int DW = 16,
  parameter int CW = 2
) (
  input logic clk,
  input logic reset,
  regfile_wb_arbiter_if.slave bus
);
  logic last_b;
  logic ga, gb, ir;
  logic [CW-1:0] cnt [NREG];
  logic [NREG-1:0] busy, inc, dec;
  always_comb begin
    ga = bus.a_valid & (~bus.b_valid | last_b);
    gb = bus.b_valid & ~ga;
    ir = (cnt[bus.issue_dest] != '1) | (bus.rf_load & (bus.rf_dest == bus.issue_dest));
    for (int i = 0; i < NREG; i++) begin
      busy[i] = cnt[i] != '0;
      inc[i] = bus.issue_valid & ir & (bus.issue_dest == 3'(i));
      dec[i] = bus.rf_load & (bus.rf_dest == 3'(i));
    end
  end
  assign bus.a_ready = ga;
  assign bus.b_ready = gb;
  assign bus.issue_ready = ir;
  assign bus.busy = busy;
  assign bus.hazard = busy[bus.src_a] | busy[bus.src_b];
  // the counter drops on the same edge the file captures rf_dest, so a reservation retires with its write
  always_ff @(posedge clk) begin
    if (reset) begin
      last_b <= 1'b1;
      bus.rf_load <= 1'b0;
      bus.rf_dest <= '0;
      bus.rf_in <= '0;
      bus.err_underflow <= 1'b0;
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      bus.rf_load <= ga | gb;
      if (ga | gb) begin
        last_b <= gb;
        bus.rf_dest <= ga ? bus.a_dest : bus.b_dest;
        bus.rf_in <= ga ? bus.a_data : bus.b_data;
      end
      for (int i = 0; i < NREG; i++) begin
        if (inc[i] & ~dec[i]) cnt[i] <= cnt[i] + 1'b1;
        else if (dec[i] & ~inc[i]) begin
          if (cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
          else bus.err_underflow <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed plus random stimulus against a queue/array reference model with a decoupled write-port monitor.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  regfile_wb_arbiter_if bus ();
  regfile_wb_arbiter dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  int m_cnt [8];
  bit m_err, m_last_b, m_load;
  int m_dest, m_data;
  typedef struct { bit load; int dest; int data; } wr_t;
  wr_t expq [$];
  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  task automatic tick();
    bit ga, gb, ir, inc, dec;
    int eb;
    @(negedge clk);
    if (reset) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_err = 0; m_last_b = 1; m_load = 0; m_dest = 0; m_data = 0;
    end else begin
      if (bus.a_valid && bus.b_valid) ga = m_last_b;
      else ga = bus.a_valid;
      gb = bus.b_valid && !ga;
      ir = m_cnt[bus.issue_dest] != 3 || (m_load && m_dest == int'(bus.issue_dest));
      eb = 0;
      foreach (m_cnt[i]) if (m_cnt[i] > 0) eb += 1 << i;
      check("a_ready", bus.a_ready, ga);
      check("b_ready", bus.b_ready, gb);
      check("issue_ready", bus.issue_ready, ir);
      check("hazard", bus.hazard, (m_cnt[bus.src_a] > 0 || m_cnt[bus.src_b] > 0) ? 1 : 0);
      check("busy", bus.busy, eb);
      check("err_underflow", bus.err_underflow, m_err);
      foreach (m_cnt[i]) begin
        inc = bus.issue_valid && ir && int'(bus.issue_dest) == i;
        dec = m_load && m_dest == i;
        if (inc && !dec) m_cnt[i]++;
        else if (dec && !inc) begin
          if (m_cnt[i] > 0) m_cnt[i]--;
          else m_err = 1;
        end
      end
      m_load = ga || gb;
      if (ga) begin m_dest = bus.a_dest; m_data = bus.a_data; m_last_b = 0; end
      if (gb) begin m_dest = bus.b_dest; m_data = bus.b_data; m_last_b = 1; end
    end
    expq.push_back('{m_load, m_dest, m_data});
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.a_valid = 0; bus.b_valid = 0; bus.issue_valid = 0;
  endtask
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("rf_load", bus.rf_load, e.load);
        check("rf_dest", bus.rf_dest, e.dest);
        check("rf_in", bus.rf_in, e.data);
      end
    end
  end
  initial begin
    idle();
    bus.a_dest = 0; bus.a_data = 0; bus.b_dest = 0; bus.b_data = 0;
    bus.issue_dest = 0; bus.src_a = 0; bus.src_b = 0;
    tick(); tick();
    reset = 0;
    bus.a_valid = 1; bus.a_dest = 3; bus.a_data = 16'h1234;
    tick();
    idle(); tick(); tick();
    reset = 1; tick(); reset = 0;
    bus.a_valid = 1; bus.a_dest = 1; bus.a_data = 16'hAAAA;
    bus.b_valid = 1; bus.b_dest = 2; bus.b_data = 16'hBBBB;
    repeat (4) tick();
    idle(); tick();
    bus.issue_valid = 1; bus.issue_dest = 5;
    repeat (4) tick();
    idle(); bus.src_a = 5; tick();
    bus.b_valid = 1; bus.b_dest = 5; bus.b_data = 16'h5555;
    repeat (3) tick();
    idle(); tick(); tick();
    bus.issue_valid = 1; bus.issue_dest = 5;
    repeat (3) tick();
    idle(); bus.a_valid = 1; bus.a_dest = 5; bus.a_data = 16'h0F0F; tick();
    idle(); bus.issue_valid = 1; bus.issue_dest = 5; tick();
    idle(); bus.a_valid = 1; bus.a_dest = 7; bus.a_data = 16'h7777; tick();
    idle(); tick(); tick(); tick();
    reset = 1; tick(); reset = 0; tick();
    bus.b_valid = 1; bus.b_dest = 4; bus.b_data = 16'h4444; tick();
    idle(); reset = 1; tick(); reset = 0;
    bus.a_valid = 1; bus.a_dest = 6; bus.a_data = 16'h6666;
    bus.b_valid = 1; bus.b_dest = 0; bus.b_data = 16'h0123;
    tick();
    idle(); tick();
    for (int n = 0; n < 600; n++) begin
      reset = $urandom_range(99) < 2;
      bus.a_valid = $urandom_range(1); bus.a_dest = 3'($urandom); bus.a_data = 16'($urandom);
      bus.b_valid = $urandom_range(1); bus.b_dest = 3'($urandom); bus.b_data = 16'($urandom);
      bus.issue_valid = $urandom_range(9) < 6; bus.issue_dest = 3'($urandom);
      bus.src_a = 3'($urandom); bus.src_b = 3'($urandom);
      tick();
    end
    reset = 0; idle(); tick();
    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
